// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction-fetch sequencer. Owns the word-addressed fetch PC, issues
// in-order requests to instruction memory under a credit limit of DEPTH
// (instructions in flight plus instructions buffered), tags every accepted
// request with its PC, and hands {instr, pc} pairs to decode through a small
// FIFO. Redirects from execute flush the FIFO and mark every response still
// in flight as stale so it is dropped when it returns.
//
// Optional build macro: FETCH_PERF_EN adds perf_redirects / perf_bubbles.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   stall                      blocks raising a new fetch request
//   redirect, redirect_pc      one-cycle redirect pulse and target PC
//   imem_req_valid/ready/addr  fetch request handshake (word address)
//   imem_rsp_valid/data        in-order response, always accepted
//   dec_valid/ready            instruction handshake towards decode
//   dec_instr, dec_pc          instruction at the FIFO head and its PC
//   perf_redirects             (FETCH_PERF_EN) accepted redirect count
//   perf_bubbles               (FETCH_PERF_EN) cycles decode waited on fetch
//
// state | meaning
// BOOT  | first cycle after reset, nothing issued, redirects ignored
// FETCH | requests issued whenever credit allows and stall is low
// HOLD  | stalled with no request pending, waits for stall to drop
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_redirects,
    output logic [31:0] perf_bubbles
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic          pend_q;
    logic [CW-1:0] inflight;
    logic [CW-1:0] kill;
    logic [CW-1:0] count;

    logic [31:0]   tag_q [DEPTH];
    logic [PW-1:0] tag_wr;
    logic [PW-1:0] tag_rd;

    logic [31:0]   buf_instr [DEPTH];
    logic [31:0]   buf_pc    [DEPTH];
    logic [PW-1:0] buf_wr;
    logic [PW-1:0] buf_rd;

    logic redir_en;
    logic credit_ok;
    logic accept;
    logic buf_push;
    logic buf_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Credit uses registered counts only: a slot freed this cycle is reused
    // next cycle, keeping the request path off the pop/response path.
    always_comb begin
        redir_en  = redirect && (state != ST_BOOT);
        credit_ok = (int'(inflight) + int'(count)) < DEPTH;
        // A pending request holds regardless of stall; only a redirect
        // withdraws it.
        imem_req_valid = (state == ST_FETCH) && !redirect &&
                         (pend_q || (!stall && credit_ok));
        imem_req_addr  = fetch_pc;
        accept         = imem_req_valid && imem_req_ready;
        buf_push       = imem_rsp_valid && !redir_en && (kill == '0);
        dec_valid      = (count != '0);
        buf_pop        = dec_valid && dec_ready;
        dec_instr      = buf_instr[buf_rd];
        dec_pc         = buf_pc[buf_rd];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_BOOT;
            fetch_pc <= RESET_PC;
            pend_q   <= 1'b0;
            inflight <= '0;
            kill     <= '0;
            count    <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            buf_wr   <= '0;
            buf_rd   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]     <= '0;
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else begin
            case (state)
                ST_BOOT:  state <= ST_FETCH;
                ST_FETCH: if (stall && !(imem_req_valid && !imem_req_ready)) state <= ST_HOLD;
                ST_HOLD:  if (!stall) state <= ST_FETCH;
                default:  state <= ST_BOOT;
            endcase

            pend_q <= imem_req_valid && !imem_req_ready;

            if (redir_en) begin
                fetch_pc <= redirect_pc;
            end else if (accept) begin
                fetch_pc <= fetch_pc + 32'd1;
            end

            inflight <= inflight + CW'(accept) - CW'(imem_rsp_valid);

            // Every response still outstanding after a redirect is stale;
            // one arriving in the redirect cycle itself is dropped directly.
            if (redir_en) begin
                kill <= inflight - CW'(imem_rsp_valid);
            end else if (imem_rsp_valid && (kill != '0)) begin
                kill <= kill - 1'b1;
            end

            if (accept) begin
                tag_q[tag_wr] <= fetch_pc;
                tag_wr        <= ptr_next(tag_wr);
            end
            if (imem_rsp_valid) begin
                tag_rd <= ptr_next(tag_rd);
            end

            if (redir_en) begin
                count  <= '0;
                buf_rd <= buf_wr;
            end else begin
                if (buf_push) begin
                    buf_instr[buf_wr] <= imem_rsp_data;
                    buf_pc[buf_wr]    <= tag_q[tag_rd];
                    buf_wr            <= ptr_next(buf_wr);
                end
                if (buf_pop) begin
                    buf_rd <= ptr_next(buf_rd);
                end
                count <= count + CW'(buf_push) - CW'(buf_pop);
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_redirects <= '0;
            perf_bubbles   <= '0;
        end else begin
            if (redir_en) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
            if ((state != ST_BOOT) && dec_ready && !dec_valid) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

    // The credit limit makes these unreachable with a well-behaved memory.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(buf_push && !buf_pop && (int'(count) == DEPTH)));
    a_kill_bound: assert property (@(posedge clk) disable iff (reset)
        (kill <= inflight) && (int'(inflight) <= DEPTH));

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam logic [31:0] RPC   = 32'hFFFF_FFFF;
    localparam int          DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_bubbles;
`endif

    fetch_ctrl #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_redirects (perf_redirects),
        .perf_bubbles   (perf_bubbles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outstanding memory transactions (memory model and PC tags in one list)
    // and the decode buffer contents, as plain queues.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          due;
        bit          stale;
    } ofl_t;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ofl_t        oq[$];
    ent_t        bq[$];
    bit          m_boot;
    bit          m_hold;
    bit          m_pend;
    logic [31:0] m_pc;
    logic [31:0] m_predir;
    logic [31:0] m_pbub;
    int          cyc;
    int          lat_lo;
    int          lat_hi;
    int          n_vec;
    int          n_err;
    logic [31:0] acc_log[$];
    logic [31:0] dec_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive_idle();
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        dec_ready      = 1'b0;
    endtask

    task automatic model_reset();
        oq.delete();
        bq.delete();
        m_boot   = 1'b1;
        m_hold   = 1'b0;
        m_pend   = 1'b0;
        m_pc     = RPC;
        m_predir = '0;
        m_pbub   = '0;
        cyc      = 0;
        acc_log.delete();
        dec_log.delete();
    endtask

    // Entered and left at a falling edge. async_mid asserts reset between
    // edges to show that outputs clear without a clock.
    task automatic do_reset(input bit async_mid);
        if (async_mid) begin
            @(posedge clk);
            #2;
        end
        reset = 1'b1;
        drive_idle();
        #1;
        n_vec++;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_instr", dec_instr, 32'd0);
        chk("rst_dec_pc", dec_pc, 32'd0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_redirects", perf_redirects, 32'd0);
        chk("rst_perf_bubbles", perf_bubbles, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive, check combinational/registered outputs against
    // the model, then advance the model across the rising edge.
    task automatic step(input bit st, input bit rdy, input bit dr, input bit rd,
                        input logic [31:0] rpc);
        bit   exp_v;
        bit   acc;
        bit   redir;
        bit   rsp;
        ofl_t e;
        ofl_t n;
        ent_t b;

        stall          = st;
        imem_req_ready = rdy;
        dec_ready      = dr;
        redirect       = rd;
        redirect_pc    = rpc;
        rsp            = (oq.size() > 0) && (oq[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? oq[0].data : $urandom;

        exp_v = !m_boot && !m_hold && !rd &&
                (m_pend || (!st && ((oq.size() + bq.size()) < DEPTH)));
        #1;
        n_vec++;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_v));
        chk("req_addr", imem_req_addr, m_pc);
        chk("dec_valid", 32'(dec_valid), 32'(bq.size() != 0));
        if (bq.size() != 0) begin
            chk("dec_instr", dec_instr, bq[0].instr);
            chk("dec_pc", dec_pc, bq[0].pc);
        end
`ifdef FETCH_PERF_EN
        chk("perf_redirects", perf_redirects, m_predir);
        chk("perf_bubbles", perf_bubbles, m_pbub);
`endif
        if (imem_req_valid && rdy) acc_log.push_back(imem_req_addr);
        if (dec_valid && dr) dec_log.push_back(dec_pc);

        @(posedge clk);
        acc   = exp_v && rdy;
        redir = rd && !m_boot;
        if (!m_boot) begin
            if (rd) m_predir++;
            if (dr && bq.size() == 0) m_pbub++;
        end
        if (dr && bq.size() > 0) void'(bq.pop_front());
        if (rsp) begin
            e = oq.pop_front();
            if (!redir && !e.stale) begin
                b.instr = e.data;
                b.pc    = e.pc;
                bq.push_back(b);
            end
        end
        if (redir) begin
            bq.delete();
            foreach (oq[i]) oq[i].stale = 1'b1;
            m_pc = rpc;
        end
        if (acc) begin
            n.pc    = m_pc;
            n.data  = $urandom;
            n.due   = cyc + int'($urandom_range(lat_lo, lat_hi));
            n.stale = 1'b0;
            oq.push_back(n);
            m_pc = m_pc + 32'd1;
        end
        if (m_boot) m_boot = 1'b0;
        else if (!m_hold) begin
            if (st && !(exp_v && !rdy)) m_hold = 1'b1;
        end else if (!st) m_hold = 1'b0;
        m_pend = exp_v && !rdy;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        lat_lo = 1;
        lat_hi = 1;
        reset  = 1'b1;
        drive_idle();
        model_reset();
        @(negedge clk);

        // Streaming from a wrapping reset PC, latency 1, decode always ready.
        do_reset(1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        chk("a_acc_n_ge3", 32'(acc_log.size() >= 3), 32'd1);
        if (acc_log.size() >= 3) begin
            chk("a_acc0", acc_log[0], 32'hFFFF_FFFF);
            chk("a_acc1", acc_log[1], 32'h0000_0000);
            chk("a_acc2", acc_log[2], 32'h0000_0001);
        end
        chk("a_dec_n_ge3", 32'(dec_log.size() >= 3), 32'd1);
        if (dec_log.size() >= 3) begin
            chk("a_dec0", dec_log[0], 32'hFFFF_FFFF);
            chk("a_dec1", dec_log[1], 32'h0000_0000);
            chk("a_dec2", dec_log[2], 32'h0000_0001);
        end

        // Credit limit with decode blocked, then a single pop.
        do_reset(1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk("b_acc_full", 32'(acc_log.size()), 32'd2);
        chk("b_valid_low", 32'(imem_req_valid), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk("b_acc_after_pop", 32'(acc_log.size()), 32'd3);
        chk("b_dec_n", 32'(dec_log.size()), 32'd1);

        // Redirect to 0x40 with two requests in flight (latency 3).
        do_reset(1'b0);
        lat_lo = 3;
        lat_hi = 3;
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
        lat_lo = 1;
        lat_hi = 1;
        repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        chk("c_acc_n_ge3", 32'(acc_log.size() >= 3), 32'd1);
        if (acc_log.size() >= 3) chk("c_acc_redir", acc_log[2], 32'h40);
        chk("c_dec_n_ge2", 32'(dec_log.size() >= 2), 32'd1);
        if (dec_log.size() >= 2) begin
            chk("c_dec0", dec_log[0], 32'h40);
            chk("c_dec1", dec_log[1], 32'h41);
        end

        // Pending request held across stall until ready, then nothing new.
        do_reset(1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        chk("d_held_valid", 32'(imem_req_valid), 32'd1);
        chk("d_held_addr", imem_req_addr, 32'hFFFF_FFFF);
        repeat (5) step(1'b1, 1'b1, 1'b1, 1'b0, '0);
        chk("d_acc_stalled", 32'(acc_log.size()), 32'd1);
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        chk("d_acc_resumed", 32'(acc_log.size() >= 2), 32'd1);
        if (acc_log.size() >= 2) chk("d_acc1", acc_log[1], 32'h0);

`ifdef FETCH_PERF_EN
        do_reset(1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        repeat (5) step(1'b1, 1'b0, 1'b1, 1'b0, '0);
        chk("e_bubbles5", perf_bubbles, 32'd5);
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1, 32'h100);
        chk("e_redirects3", perf_redirects, 32'd3);
        chk("e_bubbles8", perf_bubbles, 32'd8);
        do_reset(1'b1);
`endif

        // Randomized traffic with occasional asynchronous resets.
        lat_lo = 1;
        lat_hi = 4;
        do_reset(1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset(1'b1);
            step($urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 6,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
